// File: rtl/pc_tx_arb.sv
// pc_tx_arb -- shares the single PC transmit byte stream between N_REQ frame
// generators. Each generator raises req, receives a one-cycle ack, streams its
// frame bytes and pulses done. Grants are round-robin starting from the port
// after the last completed grantee. New grants are held off while the TX FIFO
// is almost full. Only the grantee's bytes reach the FIFO write port, one cycle
// late.
//
// Parameters
//   U_DLY       simulation delay on registered assignments; not applied in
//               this RTL
//   N_REQ       number of requesters, 2..8
//   TIMEOUT_CYC watchdog limit in cycles (PC_TX_ARB_TIMEOUT_EN builds only)
//
// Ports
//   clk_sys, rst   clock, synchronous active-high reset
//   req_vec        per-requester request level
//   ack_vec        per-requester one-cycle grant acknowledge
//   done_vec       per-requester end-of-frame pulse
//   wr_en_vec      per-requester byte strobe
//   wr_data_vec    per-requester byte, requester i on [8i+7:8i]
//   tx_afull       TX FIFO almost full, blocks new grants only
//   tx_wr_en/data  TX FIFO write port
//   tx_sof/tx_eof  first-byte / end-of-frame pulses
//   busy           high outside IDLE
//   grant_id       current or last grantee (zero-extended)
//   timeout_err    sticky watchdog flag
//
// Configuration macro: PC_TX_ARB_TIMEOUT_EN enables the ACK/BUSY watchdog.
// Without it BUSY waits indefinitely for done and timeout_err stays 0.
module pc_tx_arb #(
   parameter int U_DLY       = 1,
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_vec,
   output logic [N_REQ-1:0]   ack_vec,
   input  logic [N_REQ-1:0]   done_vec,
   input  logic [N_REQ-1:0]   wr_en_vec,
   input  logic [8*N_REQ-1:0] wr_data_vec,
   input  logic               tx_afull,
   output logic               tx_wr_en,
   output logic [7:0]         tx_wr_data,
   output logic               tx_sof,
   output logic               tx_eof,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic               timeout_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_BUSY, ST_GAP} state_t;

   state_t             state_q, state_d;
   logic [2:0]         gnt_q, gnt_d;
   logic [2:0]         rr_q, rr_d;
   logic               sof_pend_q, sof_pend_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               wr_en_q, wr_en_d;
   logic [7:0]         data_q, data_d;
   logic               sof_q, sof_d;
   logic               eof_q, eof_d;
   logic               err_q, err_d;
   logic               tmo;

   // Granted-lane mux; other lanes' strobes and done pulses never get through.
   logic               sel_en, sel_done;
   logic [7:0]         sel_data;
   always_comb begin
      sel_en   = 1'b0;
      sel_done = 1'b0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_q == 3'(i)) begin
            sel_en   = wr_en_vec[i];
            sel_done = done_vec[i];
            sel_data = wr_data_vec[8*i +: 8];
         end
      end
   end

   // Round-robin pick: rotate the doubled request vector so bit 0 is rr_q,
   // then take the lowest set bit.
   logic [2*N_REQ-1:0] req_rot;
   logic               pick_vld;
   logic [2:0]         pick_id;
   assign req_rot = {req_vec, req_vec} >> rr_q;
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!pick_vld && req_rot[j]) begin
            pick_vld = 1'b1;
            pick_id  = 3'((int'(rr_q) + j) % N_REQ);
         end
      end
   end

`ifdef PC_TX_ARB_TIMEOUT_EN
   // Cycle counter over ACK/BUSY; the count equals the number of cycles
   // already spent since the grant, so the limit fires at the TIMEOUT_CYC-th.
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign tmo = (state_q == ST_BUSY) && (cnt_q == CW'(TIMEOUT_CYC - 1)) && !sel_done;
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE && state_d == ST_ACK) cnt_d = '0;
      else if (state_q == ST_ACK || state_q == ST_BUSY) cnt_d = cnt_q + 1'b1;
   end
   always_ff @(posedge clk_sys) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_d       = rr_q;
      sof_pend_d = sof_pend_q;
      ack_d      = '0;
      wr_en_d    = 1'b0;
      data_d     = data_q;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      err_d      = err_q | tmo;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld && !tx_afull) begin
               gnt_d      = pick_id;
               sof_pend_d = 1'b1;
               ack_d      = N_REQ'(1) << pick_id;
               state_d    = ST_ACK;
            end
         end
         ST_ACK:  state_d = ST_BUSY;
         ST_BUSY: begin
            wr_en_d = sel_en;
            data_d  = sel_data;
            sof_d   = sel_en & sof_pend_q;
            if (sel_en) sof_pend_d = 1'b0;
            // A byte strobed with done is still forwarded above.
            if (sel_done || tmo) begin
               eof_d   = 1'b1;
               rr_d    = 3'((int'(gnt_q) + 1) % N_REQ);
               state_d = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         rr_q       <= '0;
         sof_pend_q <= 1'b0;
         ack_q      <= '0;
         wr_en_q    <= 1'b0;
         data_q     <= '0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_q       <= rr_d;
         sof_pend_q <= sof_pend_d;
         ack_q      <= ack_d;
         wr_en_q    <= wr_en_d;
         data_q     <= data_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         err_q      <= err_d;
      end
   end

   assign ack_vec     = ack_q;
   assign tx_wr_en    = wr_en_q;
   assign tx_wr_data  = data_q;
   assign tx_sof      = sof_q;
   assign tx_eof      = eof_q;
   assign busy        = (state_q != ST_IDLE);
   assign grant_id    = gnt_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_pc_tx_arb.sv
module tb_pc_tx_arb;
   localparam int N = 4;

   logic             clk_sys = 1'b0;
   logic             rst;
   logic [N-1:0]     req_vec, ack_vec, done_vec, wr_en_vec;
   logic [8*N-1:0]   wr_data_vec;
   logic             tx_afull, tx_wr_en, tx_sof, tx_eof, busy, timeout_err;
   logic [7:0]       tx_wr_data;
   logic [2:0]       grant_id;
   int               n_chk  = 0;
   int               n_pass = 0;

   always #5 clk_sys = ~clk_sys;

   pc_tx_arb #(.U_DLY(1), .N_REQ(N), .TIMEOUT_CYC(16)) dut (
      .clk_sys(clk_sys), .rst(rst), .req_vec(req_vec), .ack_vec(ack_vec),
      .done_vec(done_vec), .wr_en_vec(wr_en_vec), .wr_data_vec(wr_data_vec),
      .tx_afull(tx_afull), .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
      .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .grant_id(grant_id),
      .timeout_err(timeout_err)
   );

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, 32'(ack_vec), 0);
      chk({tag, "_wen"}, 32'(tx_wr_en), 0);
      chk({tag, "_data"}, 32'(tx_wr_data), 0);
      chk({tag, "_sof"}, 32'(tx_sof), 0);
      chk({tag, "_eof"}, 32'(tx_eof), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_gid"}, 32'(grant_id), 0);
      chk({tag, "_err"}, 32'(timeout_err), 0);
   endtask

   // Bounded wait for the next ack, then check which port got it.
   task automatic wait_ack(input string tag, input int p);
      int k;
      k = 0;
      while (ack_vec == '0 && k < 40) begin
         tick;
         k++;
      end
      chk({tag, "_ack"}, 32'(ack_vec), 32'(1 << p));
      chk({tag, "_gid"}, 32'(grant_id), 32'(p));
      chk({tag, "_busy"}, 32'(busy), 1);
   endtask

   // Called in the ACK cycle. Streams nbytes from port p and checks the TX
   // side one cycle later; optional port-2 noise between bytes.
   task automatic stream(input string tag, input int p, input int nbytes,
                         input logic [7:0] base, input bit sc_done,
                         input bit noise, input bit drop);
      logic [7:0] b;
      tick;
      chk({tag, "_ack1cyc"}, 32'(ack_vec), 0);
      for (int i = 0; i < nbytes; i++) begin
         if (noise) begin
            wr_en_vec = 4'b0100;
            wr_data_vec[8*2 +: 8] = 8'hAA;
            done_vec = (i == 0) ? 4'b0100 : 4'b0000;
            tick;
            chk({tag, "_noise_wen"}, 32'(tx_wr_en), 0);
            chk({tag, "_noise_eof"}, 32'(tx_eof), 0);
            chk({tag, "_noise_notAA"}, 32'(tx_wr_data === 8'hAA), 0);
            done_vec = '0;
         end
         b = base + 8'(i);
         wr_en_vec = 4'(1 << p);
         wr_data_vec[8*p +: 8] = b;
         if (sc_done && i == nbytes - 1) done_vec = 4'(1 << p);
         tick;
         chk({tag, "_wen"}, 32'(tx_wr_en), 1);
         chk({tag, "_data"}, 32'(tx_wr_data), 32'(b));
         chk({tag, "_sof"}, 32'(tx_sof), (i == 0) ? 1 : 0);
         chk({tag, "_eof"}, 32'(tx_eof), (sc_done && i == nbytes - 1) ? 1 : 0);
      end
      wr_en_vec = '0;
      if (!sc_done) begin
         done_vec = 4'(1 << p);
         tick;
         chk({tag, "_eof"}, 32'(tx_eof), 1);
         chk({tag, "_wen_done"}, 32'(tx_wr_en), 0);
      end
      done_vec = '0;
      if (drop) req_vec[p] = 1'b0;
      chk({tag, "_gap_busy"}, 32'(busy), 1);
      tick;
      chk({tag, "_eof_clr"}, 32'(tx_eof), 0);
      chk({tag, "_idle"}, 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_vec = '0; done_vec = '0; wr_en_vec = '0;
      wr_data_vec = '0; tx_afull = 1'b0;
      tick; tick;
      chk_all_zero("reset");
      rst = 1'b0;

      // 1: single request on port 0, 12-byte frame, ack exactly one cycle later
      req_vec = 4'b0001;
      tick;
      chk("t1_ack_lat", 32'(ack_vec), 1);
      chk("t1_gid", 32'(grant_id), 0);
      stream("t1", 0, 12, 8'hC0, 1'b0, 1'b0, 1'b1);

      // 2: all four requesting from rr_ptr=0 -> 0,1,2,3,0
      rst = 1'b1; tick; rst = 1'b0;
      req_vec = 4'b1111;
      wait_ack("t2_g0", 0); stream("t2_s0", 0, 3, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_ack("t2_g1", 1); stream("t2_s1", 1, 3, 8'h20, 1'b0, 1'b0, 1'b0);
      wait_ack("t2_g2", 2); stream("t2_s2", 2, 3, 8'h40, 1'b0, 1'b0, 1'b0);
      wait_ack("t2_g3", 3); stream("t2_s3", 3, 3, 8'h60, 1'b0, 1'b0, 1'b0);
      wait_ack("t2_g4", 0); stream("t2_s4", 0, 3, 8'h80, 1'b0, 1'b0, 1'b0);
      req_vec = '0;

      // 3: port 1 streams while port 2 strobes 8'hAA and pulses done
      req_vec = 4'b0110;
      wait_ack("t3", 1);
      stream("t3", 1, 4, 8'h10, 1'b0, 1'b1, 1'b1);
      req_vec = '0;

      // 4: afull blocks the grant to port 3 for 20 cycles
      tx_afull = 1'b1;
      req_vec = 4'b1000;
      for (int i = 0; i < 20; i++) begin
         tick;
         chk("t4_hold_ack", 32'(ack_vec), 0);
      end
      tx_afull = 1'b0;
      tick;
      chk("t4_ack", 32'(ack_vec), 32'b1000);
      chk("t4_gid", 32'(grant_id), 3);
      stream("t4", 3, 2, 8'h30, 1'b1, 1'b0, 1'b1);

      // 6: full frame on 2 (rr_ptr -> 3), then reset mid-frame on port 3
      req_vec = 4'b0100;
      wait_ack("t6a", 2);
      stream("t6a", 2, 2, 8'h50, 1'b0, 1'b0, 1'b1);
      req_vec = 4'b1000;
      wait_ack("t6b", 3);
      tick;
      wr_en_vec = 4'b1000;
      wr_data_vec[8*3 +: 8] = 8'h61;
      tick;
      chk("t6_byte_wen", 32'(tx_wr_en), 1);
      chk("t6_byte_data", 32'(tx_wr_data), 32'h61);
      rst = 1'b1;
      tick;
      chk_all_zero("t6_rst");
      rst = 1'b0;
      wr_en_vec = '0;
      req_vec = 4'b1111;
      wait_ack("t6_after_rst", 0);

`ifdef PC_TX_ARB_TIMEOUT_EN
      // 5: port 0 never sends done; watchdog fires on the 16th cycle
      for (int i = 0; i < 15; i++) tick;
      chk("t5_err_early", 32'(timeout_err), 0);
      tick;
      chk("t5_err", 32'(timeout_err), 1);
      chk("t5_eof", 32'(tx_eof), 1);
      wait_ack("t5_next", 1);
`else
      // Without the watchdog a grant with no done stays in BUSY
      for (int i = 0; i < 40; i++) tick;
      chk("nowd_busy", 32'(busy), 1);
      chk("nowd_err", 32'(timeout_err), 0);
      chk("nowd_eof", 32'(tx_eof), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
